// File: rtl/maint_scheduler_pkg.sv
// Shared opcodes and constants for the refresh scheduler / instruction arbiter.
package maint_scheduler_pkg;

    localparam logic [3:0] END_ISEQ = 4'h0;
    localparam logic [3:0] WAIT     = 4'h1;
    localparam logic [3:0] REF      = 4'h8;
    localparam logic [3:0] PRE      = 4'h9;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_HOST  = 2'd1,
        OWN_MAINT = 2'd2
    } own_state_t;

    localparam int unsigned DEF_MAX_POSTPONE = 8;
    localparam int unsigned TREFI_W          = 28;

endpackage

// File: rtl/maint_scheduler_trefi_counter.sv
// tREFI down-counter; emits a registered one-cycle expiry pulse every trefi cycles.
module maint_scheduler_trefi_counter
    import maint_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [TREFI_W-1:0] trefi,
    input  logic               refresh_en,
    output logic               expire
);

    logic [TREFI_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt    <= trefi;
            expire <= 1'b0;
        end else if (!refresh_en || trefi == '0) begin
            cnt    <= trefi;
            expire <= 1'b0;
        end else if (cnt <= TREFI_W'(1)) begin
            // <= also catches a stale 0 left after trefi was reprogrammed
            cnt    <= trefi;
            expire <= 1'b1;
        end else begin
            cnt    <= cnt - TREFI_W'(1);
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/maint_scheduler.sv
// Refresh scheduler and host/maintenance arbiter for the dispatcher port.
// Build option: REF_POSTPONE_EN lets refresh yield to host traffic until saturation.
//
// state     | meaning
// OWN_IDLE  | no owner, grant decision made this cycle
// OWN_HOST  | host stream owns dispatcher until END_ISEQ is accepted
// OWN_MAINT | maintenance stream owns dispatcher until autoref_ack
module maint_scheduler
    import maint_scheduler_pkg::*;
#(
    parameter int unsigned MAX_POSTPONE = DEF_MAX_POSTPONE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [27:0] trefi,
    input  logic        refresh_en,
    input  logic        host_instr_en,
    input  logic [31:0] host_instr,
    output logic        host_ack,
    input  logic        maint_instr_en,
    input  logic [31:0] maint_instr,
    output logic        maint_ack,
    output logic        autoref_req,
    input  logic        autoref_ack,
    output logic        disp_instr_en,
    output logic [31:0] disp_instr,
    input  logic        disp_ack,
    output logic [3:0]  pending_cnt,
    output logic        ref_overflow
);

    localparam logic [3:0] MAX_P = 4'(MAX_POSTPONE);

    own_state_t state;
    logic       expire;
    logic       ack_valid;
    logic       forced;
    logic       maint_elig;
    logic       maint_start;

    maint_scheduler_trefi_counter u_trefi_counter (
        .clk        (clk),
        .rstn       (rstn),
        .trefi      (trefi),
        .refresh_en (refresh_en),
        .expire     (expire)
    );

    assign ack_valid = autoref_ack && (pending_cnt != 4'd0);

`ifdef REF_POSTPONE_EN
    assign forced = (pending_cnt == MAX_P);
`else
    assign forced = (pending_cnt != 4'd0);
`endif

    assign maint_elig = (pending_cnt != 4'd0) && (!host_instr_en || forced);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending_cnt  <= 4'd0;
            ref_overflow <= 1'b0;
        end else if (expire && !ack_valid) begin
            if (pending_cnt == MAX_P)
                ref_overflow <= 1'b1;
            else
                pending_cnt <= pending_cnt + 4'd1;
        end else if (!expire && ack_valid) begin
            pending_cnt <= pending_cnt - 4'd1;
        end
    end

    // autoref_req trails the grant by one cycle and is never held
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= OWN_IDLE;
            maint_start <= 1'b0;
            autoref_req <= 1'b0;
        end else begin
            maint_start <= 1'b0;
            autoref_req <= maint_start && (state == OWN_MAINT);
            case (state)
                OWN_IDLE: begin
                    if (maint_elig) begin
                        state       <= OWN_MAINT;
                        maint_start <= 1'b1;
                    end else if (host_instr_en) begin
                        state <= OWN_HOST;
                    end
                end
                OWN_HOST: begin
                    if (disp_ack && host_instr[31:28] == END_ISEQ)
                        state <= OWN_IDLE;
                end
                OWN_MAINT: begin
                    if (autoref_ack)
                        state <= OWN_IDLE;
                end
                default: state <= OWN_IDLE;
            endcase
        end
    end

    always_comb begin
        disp_instr_en = 1'b0;
        disp_instr    = {END_ISEQ, 28'd0};
        host_ack      = 1'b0;
        maint_ack     = 1'b0;
        case (state)
            OWN_HOST: begin
                disp_instr_en = host_instr_en;
                disp_instr    = host_instr;
                host_ack      = disp_ack;
            end
            OWN_MAINT: begin
                disp_instr_en = maint_instr_en;
                disp_instr    = maint_instr;
                maint_ack     = disp_ack;
            end
            default: ;
        endcase
    end

endmodule
